// File: rtl/spi_master_param_if.sv
// Handshake and serial bus bundle for spi_master_param.
// The master modport is the DUT view and the slave modport is the controller/peripheral view.
interface spi_master_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 1
);
    localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic [DATA_WIDTH-1:0] DATA;
    logic [SEL_W-1:0]      SEL;
    logic                  HOLD;
    logic                  TRG;
    logic                  RDY;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  DONE;
    logic                  MOSI;
    logic                  MISO;
    logic                  SCK;
    logic [NUM_CS-1:0]     CS_N;

    modport master (
        input  DATA, SEL, HOLD, TRG, MISO,
        output RDY, DATA_OUT, DONE, MOSI, SCK, CS_N
    );

    modport slave (
        output DATA, SEL, HOLD, TRG, MISO,
        input  RDY, DATA_OUT, DONE, MOSI, SCK, CS_N
    );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: one word per TRG/RDY handshake,
// configurable SCK divider, CPOL/CPHA, bit order and chip-select hold for bursts.
module spi_master_param #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 1,
    parameter int CLK_DIV    = 1,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    spi_master_param_if.master   bus
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LAST   = 2 * DATA_WIDTH;
    localparam int EDGE_W = $clog2(LAST + 2);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t                r_state;
    logic [DIV_W-1:0]      r_div;
    logic [EDGE_W-1:0]     r_edge;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [NUM_CS-1:0]     r_cs_n;
    logic                  r_hold;
    logic                  r_samp;
    logic                  r_rdy;
    logic                  r_done;
    logic                  r_mosi;
    logic                  r_sck;

    logic                  w_tick;
    logic [EDGE_W-1:0]     w_k;
    logic                  w_sample_edge;
    logic [DATA_WIDTH-1:0] w_rx_next;
    logic [DATA_WIDTH-1:0] w_tx_sh;
    logic                  w_tx_bit;
    logic                  w_tx_sh_bit;
    logic                  w_first_bit;
    logic [NUM_CS-1:0]     w_cs_sel;

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_k    = r_edge + 1'b1;
    // A sampling SCK edge is seen on the pin one cycle later; r_samp delays the MISO capture to match.
    assign w_sample_edge = (r_state != IDLE) && w_tick && (w_k <= EDGE_W'(LAST)) && (w_k[0] == ~CPHA);
    assign w_rx_next = !r_samp ? r_rx :
                       MSB_FIRST ? {r_rx[DATA_WIDTH-2:0], bus.MISO} : {bus.MISO, r_rx[DATA_WIDTH-1:1]};

    assign w_tx_sh     = MSB_FIRST ? (r_tx << 1) : (r_tx >> 1);
    assign w_tx_bit    = MSB_FIRST ? r_tx[DATA_WIDTH-1] : r_tx[0];
    assign w_tx_sh_bit = MSB_FIRST ? w_tx_sh[DATA_WIDTH-1] : w_tx_sh[0];
    assign w_first_bit = MSB_FIRST ? bus.DATA[DATA_WIDTH-1] : bus.DATA[0];

    // Out-of-range SEL leaves every chip select deasserted.
    always_comb begin
        w_cs_sel = '1;
        for (int i = 0; i < NUM_CS; i++) w_cs_sel[i] = (int'(bus.SEL) != i);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_edge  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_dout  <= '0;
            r_cs_n  <= '1;
            r_hold  <= 1'b0;
            r_samp  <= 1'b0;
            r_rdy   <= 1'b0;
            r_done  <= 1'b0;
            r_mosi  <= 1'b0;
            r_sck   <= CPOL;
        end else begin
            r_done <= 1'b0;
            r_samp <= w_sample_edge;
            r_rx   <= w_rx_next;
            case (r_state)
                IDLE: begin
                    if (r_rdy && bus.TRG) begin
                        r_rdy   <= 1'b0;
                        r_tx    <= bus.DATA;
                        r_hold  <= bus.HOLD;
                        r_cs_n  <= w_cs_sel;
                        r_mosi  <= (CPHA == 1'b0) ? w_first_bit : 1'b0;
                        r_div   <= '0;
                        r_edge  <= '0;
                        r_state <= LEAD;
                    end else begin
                        r_rdy <= 1'b1;
                    end
                end
                default: begin
                    if (!w_tick) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div  <= '0;
                        r_edge <= w_k;
                        if (w_k == EDGE_W'(LAST + 1)) begin
                            r_dout  <= w_rx_next;
                            r_done  <= 1'b1;
                            r_rdy   <= 1'b1;
                            r_mosi  <= 1'b0;
                            r_state <= IDLE;
                            if (!r_hold) r_cs_n <= '1;
                        end else begin
                            r_sck <= ~r_sck;
                            if (w_k == EDGE_W'(1))    r_state <= SHIFT;
                            if (w_k == EDGE_W'(LAST)) r_state <= TRAIL;
                            if (CPHA == 1'b0) begin
                                if (!w_k[0] && (w_k != EDGE_W'(LAST))) begin
                                    r_tx   <= w_tx_sh;
                                    r_mosi <= w_tx_sh_bit;
                                end
                            end else if (w_k[0]) begin
                                r_tx   <= w_tx_sh;
                                r_mosi <= w_tx_bit;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.RDY      = r_rdy;
    assign bus.DONE     = r_done;
    assign bus.DATA_OUT = r_dout;
    assign bus.MOSI     = r_mosi;
    assign bus.SCK      = r_sck;
    assign bus.CS_N     = r_cs_n;
endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: default mode loopback vectors, CPOL/CPHA=1 LSB-first 16-bit,
// CS hold bursts, back-to-back TRG, ignored TRG, out-of-range SEL and mid-transfer reset.
module tb_spi_master_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    spi_master_param_if #(.DATA_WIDTH(8),  .NUM_CS(1)) if0();
    spi_master_param_if #(.DATA_WIDTH(16), .NUM_CS(1)) if1();
    spi_master_param_if #(.DATA_WIDTH(8),  .NUM_CS(4)) if2();
    spi_master_param_if #(.DATA_WIDTH(8),  .NUM_CS(5)) if3();

    spi_master_param u0 (.CLK(clk), .RESET_N(rst_n), .bus(if0));
    spi_master_param #(.DATA_WIDTH(16), .CLK_DIV(4), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0))
        u1 (.CLK(clk), .RESET_N(rst_n), .bus(if1));
    spi_master_param #(.NUM_CS(4)) u2 (.CLK(clk), .RESET_N(rst_n), .bus(if2));
    spi_master_param #(.NUM_CS(5)) u3 (.CLK(clk), .RESET_N(rst_n), .bus(if3));

    assign if0.MISO = if0.MOSI;
    assign if2.MISO = if2.MOSI;
    assign if3.MISO = if3.MOSI;

    // Mode-3 LSB-first slave: presents the next bit of its word on every falling SCK edge.
    logic [15:0] s1_word = 16'h1234;
    int s1_cnt = 0;
    always @(negedge if1.SCK or posedge if1.CS_N[0]) begin
        if (if1.CS_N[0]) s1_cnt = 0;
        else             s1_cnt = s1_cnt + 1;
    end
    assign if1.MISO = (s1_cnt >= 1 && s1_cnt <= 16) ? s1_word[s1_cnt-1] : 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_bits;
        logic [7:0] exp_dout;
        int         exp_lat;
    } vec_t;

    // Single word on u0; caller is at a negedge with RDY high.
    task automatic run0(input logic [7:0] d, output int lat, output int rises,
                        output logic [7:0] bits, output int cs_low);
        logic prev_sck;
        int c;
        if0.DATA = d; if0.SEL = '0; if0.HOLD = 1'b0; if0.TRG = 1'b1;
        prev_sck = 1'b0;
        lat = -1; rises = 0; bits = '0; cs_low = 0; c = 0;
        @(posedge clk);
        while (lat < 0 && c < 60) begin
            @(negedge clk);
            if (c == 0) if0.TRG = 1'b0;
            if (if0.SCK && !prev_sck) begin bits = {bits[6:0], if0.MOSI}; rises++; end
            prev_sck = if0.SCK;
            if (if0.DONE) lat = c;
            else if (if0.CS_N[0] == 1'b0) cs_low++;
            c++;
        end
    endtask

    initial begin
        vec_t tbl [5];
        int lat, rises, cs_low, c, nd, bad, d1, d2, d3, first_fall, last_rise;
        logic [7:0] bits;
        logic [15:0] rbits;
        logic [7:0] words [3];
        logic prev_sck, prev_mosi, fall;

        tbl[0] = '{8'hA5, 8'hA5, 8'hA5, 17};
        tbl[1] = '{8'h00, 8'h00, 8'h00, 17};
        tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 17};
        tbl[3] = '{8'h81, 8'h81, 8'h81, 17};
        tbl[4] = '{8'h3C, 8'h3C, 8'h3C, 17};

        if0.DATA = '0; if0.SEL = '0; if0.HOLD = 1'b0; if0.TRG = 1'b0;
        if1.DATA = '0; if1.SEL = '0; if1.HOLD = 1'b0; if1.TRG = 1'b0;
        if2.DATA = '0; if2.SEL = '0; if2.HOLD = 1'b0; if2.TRG = 1'b0;
        if3.DATA = '0; if3.SEL = '0; if3.HOLD = 1'b0; if3.TRG = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_rdy",   32'(if0.RDY), 32'h0);
        chk("rst_done",  32'(if0.DONE), 32'h0);
        chk("rst_dout",  32'(if0.DATA_OUT), 32'h0);
        chk("rst_mosi",  32'(if0.MOSI), 32'h0);
        chk("rst_sck0",  32'(if0.SCK), 32'h0);
        chk("rst_cs0",   32'(if0.CS_N), 32'h1);
        chk("rst_sck1",  32'(if1.SCK), 32'h1);
        chk("rst_cs2",   32'(if2.CS_N), 32'hF);
        rst_n = 1'b1;
        #1 chk("rdy_before_edge", 32'(if0.RDY), 32'h0);
        @(negedge clk);
        chk("rdy_after_release", 32'(if0.RDY), 32'h1);

        // Default-mode loopback vectors
        for (int i = 0; i < 5; i++) begin
            run0(tbl[i].data, lat, rises, bits, cs_low);
            chk($sformatf("v%0d_lat", i),   32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("v%0d_rises", i), 32'(rises), 32'd8);
            chk($sformatf("v%0d_mosi", i),  32'(bits), 32'(tbl[i].exp_bits));
            chk($sformatf("v%0d_dout", i),  32'(if0.DATA_OUT), 32'(tbl[i].exp_dout));
            chk($sformatf("v%0d_cslow", i), 32'(cs_low), 32'd17);
            chk($sformatf("v%0d_end", i),   {28'h0, if0.RDY, if0.CS_N[0], if0.MOSI, if0.SCK}, 32'hC);
        end

        // TRG held high: three words, one-cycle CS gap each
        words[0] = 8'h12; words[1] = 8'hE7; words[2] = 8'h69;
        if0.DATA = words[0]; if0.TRG = 1'b1;
        @(posedge clk);
        c = 0; nd = 0; bad = 0; d1 = -1; d2 = -1; d3 = -1;
        while (nd < 3 && c < 100) begin
            @(negedge clk);
            if (if0.DONE) begin
                chk($sformatf("b2b_dout%0d", nd), 32'(if0.DATA_OUT), 32'(words[nd]));
                if (nd == 0) d1 = c; else if (nd == 1) d2 = c; else d3 = c;
                nd++;
                if (nd < 3) if0.DATA = words[nd]; else if0.TRG = 1'b0;
            end else if (if0.CS_N[0]) bad++;
            c++;
        end
        chk("b2b_done1", 32'(d1), 32'd17);
        chk("b2b_done2", 32'(d2), 32'd35);
        chk("b2b_done3", 32'(d3), 32'd53);
        chk("b2b_cs_gap", 32'(bad), 32'd0);

        // TRG pulse mid-transfer is dropped
        if0.DATA = 8'h5C; if0.TRG = 1'b1;
        @(posedge clk);
        c = 0; nd = 0; d1 = -1;
        while (c < 45) begin
            @(negedge clk);
            if (c == 0) if0.TRG = 1'b0;
            if (c == 5) if0.TRG = 1'b1;
            if (c == 6) if0.TRG = 1'b0;
            if (if0.DONE) begin nd++; if (d1 < 0) d1 = c; end
            c++;
        end
        chk("ign_ndone", 32'(nd), 32'd1);
        chk("ign_lat", 32'(d1), 32'd17);
        chk("ign_dout", 32'(if0.DATA_OUT), 32'h5C);
        chk("ign_cs_idle", 32'(if0.CS_N), 32'h1);

        // CPOL=1 CPHA=1 CLK_DIV=4 LSB-first 16-bit
        if1.DATA = 16'hBEEF; if1.TRG = 1'b1;
        prev_sck = if1.SCK; prev_mosi = if1.MOSI;
        @(posedge clk);
        c = 0; d1 = -1; first_fall = -1; last_rise = -1; rises = 0; bad = 0; rbits = '0;
        while (d1 < 0 && c < 200) begin
            @(negedge clk);
            if (c == 0) if1.TRG = 1'b0;
            fall = prev_sck && !if1.SCK;
            if (!prev_sck && if1.SCK) begin
                if (rises < 16) rbits[rises] = if1.MOSI;
                rises++; last_rise = c;
            end
            if (fall && first_fall < 0) first_fall = c;
            if (if1.DONE) d1 = c;
            else if (if1.MOSI !== prev_mosi && !fall) bad++;
            prev_sck = if1.SCK; prev_mosi = if1.MOSI;
            c++;
        end
        chk("m3_first_fall", 32'(first_fall), 32'd4);
        chk("m3_rises", 32'(rises), 32'd16);
        chk("m3_last_rise", 32'(last_rise), 32'd128);
        chk("m3_mosi_edges", 32'(bad), 32'd0);
        chk("m3_mosi_word", 32'(rbits), 32'hBEEF);
        chk("m3_done", 32'(d1), 32'd132);
        chk("m3_dout", 32'(if1.DATA_OUT), 32'h1234);
        chk("m3_sck_idle", 32'(if1.SCK), 32'h1);

        // NUM_CS=4 SEL=2 held burst
        if2.DATA = 8'h5A; if2.SEL = 2'd2; if2.HOLD = 1'b1; if2.TRG = 1'b1;
        @(posedge clk);
        c = 0; nd = 0; bad = 0; d1 = -1; d2 = -1;
        while (nd < 2 && c < 80) begin
            @(negedge clk);
            if (c == 0) begin if2.HOLD = 1'b0; if2.DATA = 8'hC3; end
            if (if2.DONE) begin
                if (nd == 0) begin
                    d1 = c;
                    chk("hold_dout1", 32'(if2.DATA_OUT), 32'h5A);
                    chk("hold_cs_kept", 32'(if2.CS_N), 32'hB);
                end else begin
                    d2 = c; if2.TRG = 1'b0;
                    chk("hold_dout2", 32'(if2.DATA_OUT), 32'hC3);
                    chk("hold_cs_rel", 32'(if2.CS_N), 32'hF);
                end
                nd++;
            end else if (if2.CS_N !== 4'b1011) bad++;
            c++;
        end
        chk("hold_done1", 32'(d1), 32'd17);
        chk("hold_done2", 32'(d2), 32'd35);
        chk("hold_cs_steady", 32'(bad), 32'd0);

        // Out-of-range SEL
        if3.DATA = 8'h96; if3.SEL = 3'd5; if3.TRG = 1'b1;
        prev_sck = 1'b0;
        @(posedge clk);
        c = 0; d1 = -1; rises = 0; bad = 0;
        while (d1 < 0 && c < 60) begin
            @(negedge clk);
            if (c == 0) if3.TRG = 1'b0;
            if (!prev_sck && if3.SCK) rises++;
            prev_sck = if3.SCK;
            if (if3.CS_N !== 5'b11111) bad++;
            if (if3.DONE) d1 = c;
            c++;
        end
        chk("oob_cs", 32'(bad), 32'd0);
        chk("oob_rises", 32'(rises), 32'd8);
        chk("oob_done", 32'(d1), 32'd17);
        chk("oob_dout", 32'(if3.DATA_OUT), 32'h96);

        // Reset in the middle of a word
        if0.DATA = 8'h0F; if0.TRG = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (k == 0) if0.TRG = 1'b0;
        end
        chk("mid_pre_sck", 32'(if0.SCK), 32'h1);
        chk("mid_pre_mosi", 32'(if0.MOSI), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_sck", 32'(if0.SCK), 32'h0);
        chk("mid_cs", 32'(if0.CS_N), 32'h1);
        chk("mid_mosi", 32'(if0.MOSI), 32'h0);
        chk("mid_rdy", 32'(if0.RDY), 32'h0);
        chk("mid_dout", 32'(if0.DATA_OUT), 32'h0);
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if0.DONE) nd++;
            if (k == 3) rst_n = 1'b1;
        end
        chk("mid_no_done", 32'(nd), 32'd0);
        chk("mid_rdy_back", 32'(if0.RDY), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
